instr_fetch_unit: RTL

Initiator side of the instruction memory interface. Holds the program counter, issues word-aligned read requests to the single-cycle instruction memory bank, and buffers returned instructions with their PCs in a small prefetch queue. The queue drives the IF/ID boundary through a valid/ready handshake. Branch and jump redirects from later stages flush the queue and reload the PC.

---
 rtl/if_pkg.sv | 15 +
 rtl/fetch_queue.sv | 79 +++++++
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h00000000;

  // One prefetch queue slot: the fetched word tagged with its byte address.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions with flush.
module fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  fetch_entry_t     mem_q [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push_ok_c;
  logic             pop_ok_c;

  assign full_o  = (count_q == CNT_W'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign pop_ok_c  = pop_i & ~empty_o;
  assign push_ok_c = push_i & (~full_o | pop_ok_c);

  // Pointer and occupancy update; flush wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while the slot is occupied.
  always_ff @(posedge clk) begin
    if (push_ok_c && !flush_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, instruction memory requests and IF/ID prefetch queue.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = if_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = if_pkg::DATA_W,
  parameter int unsigned       QDEPTH   = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_memread,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_readdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4
);

  // Queue entries use the package widths; the top parameters are expected to match them.
  localparam int unsigned E_ADDR_W = if_pkg::ADDR_W;
  localparam int unsigned E_DATA_W = if_pkg::DATA_W;

  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    pc_d;
  logic [DATA_W-1:0]    last_instr_q;
  logic [DATA_W-1:0]    last_instr_d;
  logic [ADDR_W-1:0]    last_pc_q;
  logic [ADDR_W-1:0]    last_pc_d;
  logic                 pop_c;
  logic                 fetch_c;
  logic                 q_full;
  logic                 q_empty;
  if_pkg::fetch_entry_t push_entry;
  if_pkg::fetch_entry_t head_entry;

  // Redirect voids any handshake and blocks fetch for the cycle.
  assign pop_c   = id_valid & id_ready & ~redirect_valid;
  assign fetch_c = ~rst & ~redirect_valid & (~q_full | pop_c);

  assign imem_memread = fetch_c;
  assign imem_addr    = pc_q;

  assign push_entry.pc    = E_ADDR_W'(pc_q);
  assign push_entry.instr = E_DATA_W'(imem_readdata);

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fetch_c),
    .push_data_i (push_entry),
    .pop_i       (pop_c),
    .flush_i     (redirect_valid),
    .head_o      (head_entry),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // ID side shows the queue head, or the last head seen once the queue drains.
  assign id_valid    = ~q_empty;
  assign id_instr    = id_valid ? DATA_W'(head_entry.instr) : last_instr_q;
  assign id_pc       = id_valid ? ADDR_W'(head_entry.pc) : last_pc_q;
  assign id_pc_plus4 = id_pc + ADDR_W'(4);

  // Next PC: aligned redirect target, sequential advance on fetch, else hold.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (fetch_c) begin
      pc_d = pc_q + ADDR_W'(4);
    end
  end

  // Capture the presented head so the ID outputs can hold it when empty.
  always_comb begin
    last_instr_d = last_instr_q;
    last_pc_d    = last_pc_q;
    if (id_valid) begin
      last_instr_d = DATA_W'(head_entry.instr);
      last_pc_d    = ADDR_W'(head_entry.pc);
    end
  end

  // PC and held-head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      last_instr_q <= DATA_W'(if_pkg::NOP_INSTR);
      last_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      last_instr_q <= last_instr_d;
      last_pc_q    <= last_pc_d;
    end
  end

endmodule
